shift_exec_pipe: RTL and testbench

A two-stage pipelined 64-bit shift unit for the execute path of the pipelined processor. It sits directly upstream of the dynamic shift logic's consumers in EX/MEM and directly downstream of the ID/EX operand latch.
- Stage 1 applies the fine shift, shamt[2:0] (0-7 bits), and registers the partial result.
- Stage 2 applies the coarse shift, shamt[5:3] (multiples of 8), and registers the final result.
- Supports LSL, LSR, ASR and ROR, with a valid/ready handshake, pipeline flush and destination-tag passthrough.

---
 rtl/shift_exec_pipe_pkg.sv | 15 +
 rtl/shift_exec_pipe_if.sv | 32 +++
 rtl/shift_exec_pipe_stage_unit.sv | 35 +++
 rtl/shift_exec_pipe.sv | 108 ++++++++++
 tb/tb_shift_exec_pipe.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/shift_exec_pipe_pkg.sv
// rtl/shift_exec_pipe_pkg.sv - shared types and widths for the pipelined shift unit
package shift_pkg;

    localparam int DATA_W  = 64;
    localparam int SHAMT_W = 6;
    localparam int TAG_W   = 5;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_op_t;

endpackage

// File: rtl/shift_exec_pipe_if.sv
// rtl/shift_exec_pipe_if.sv - operand-in / result-out handshake bundle for shift_exec_pipe
interface shift_exec_pipe_if
    import shift_pkg::*;
#(
    parameter int DATA_W  = shift_pkg::DATA_W,
    parameter int SHAMT_W = shift_pkg::SHAMT_W,
    parameter int TAG_W   = shift_pkg::TAG_W
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHAMT_W-1:0] in_shamt;
    shift_op_t          in_op;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               out_zero;

    // Upstream issue logic and downstream consumer, seen from outside the unit
    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero
    );
endinterface

// File: rtl/shift_exec_pipe_stage_unit.sv
// rtl/shift_exec_pipe_stage_unit.sv - combinational shifter for 0-7 steps of SCALE bits
module shift_stage_unit
    import shift_pkg::*;
#(
    parameter int SCALE = 1
) (
    input  logic [DATA_W-1:0] data_i,
    input  shift_op_t         op_i,
    input  logic [2:0]        amt_i,
    input  logic              fill_i,
    output logic [DATA_W-1:0] data_o
);
    logic [SHAMT_W:0]  sh;
    logic [DATA_W-1:0] srl;
    logic [DATA_W-1:0] sll;
    logic [DATA_W-1:0] wrap;
    logic [DATA_W-1:0] fill_mask;

    always_comb begin
        sh        = 7'(amt_i) * 7'(SCALE);
        srl       = data_i >> sh;
        sll       = data_i << sh;
        // A shift of 0 turns into a shift by DATA_W, which yields 0, so ROR by 0 is exact
        wrap      = data_i << (7'(DATA_W) - sh);
        fill_mask = ~({DATA_W{1'b1}} >> sh);

        data_o = sll;
        unique case (op_i)
            SH_LSL: data_o = sll;
            SH_LSR: data_o = srl;
            SH_ASR: data_o = srl | (fill_i ? fill_mask : '0);
            SH_ROR: data_o = srl | wrap;
        endcase
    end
endmodule

// File: rtl/shift_exec_pipe.sv
// rtl/shift_exec_pipe.sv - two-stage 64-bit LSL/LSR/ASR/ROR unit: fine shift, then coarse shift
module shift_exec_pipe
    import shift_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    shift_exec_pipe_if.slave    bus
);
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    shift_op_t         s1_op_q,    s1_op_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
    logic [2:0]        s1_coarse_q, s1_coarse_d;
    logic              s1_sign_q,  s1_sign_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q,  s2_data_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;

    logic              s1_adv, s2_adv;
    logic [DATA_W-1:0] fine_res, coarse_res;

    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;

    shift_stage_unit #(.SCALE(1)) u_fine (
        .data_i (bus.in_data),
        .op_i   (bus.in_op),
        .amt_i  (bus.in_shamt[2:0]),
        .fill_i (bus.in_data[DATA_W-1]),
        .data_o (fine_res)
    );

    // The sign travels with the op so the coarse ASR fill does not depend on partial's MSB
    shift_stage_unit #(.SCALE(8)) u_coarse (
        .data_i (s1_data_q),
        .op_i   (s1_op_q),
        .amt_i  (s1_coarse_q),
        .fill_i (s1_sign_q),
        .data_o (coarse_res)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s1_coarse_d = s1_coarse_q;
        s1_sign_d   = s1_sign_q;
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_tag_d    = s2_tag_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_d = coarse_res;
                    s2_tag_d  = s1_tag_q;
                end
            end
            if (s1_adv) begin
                s1_valid_d = bus.in_valid;
                if (bus.in_valid) begin
                    s1_data_d   = fine_res;
                    s1_op_d     = bus.in_op;
                    s1_tag_d    = bus.in_tag;
                    s1_coarse_d = bus.in_shamt[SHAMT_W-1:3];
                    s1_sign_d   = bus.in_data[DATA_W-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_op_q     <= SH_LSL;
            s1_tag_q    <= '0;
            s1_coarse_q <= '0;
            s1_sign_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s1_coarse_q <= s1_coarse_d;
            s1_sign_q   <= s1_sign_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_tag   = s2_tag_q;
    assign bus.out_zero  = (s2_data_q == '0);
endmodule

// File: tb/tb_shift_exec_pipe.sv
// tb/tb_shift_exec_pipe.sv - directed-vector bench for shift_exec_pipe
module tb_shift_exec_pipe;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    shift_exec_pipe_if bus ();

    shift_exec_pipe dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input shift_op_t op, input logic [63:0] d, input logic [5:0] sh,
                         input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_shamt = sh;
        bus.in_tag   = tag;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [63:0] d, input logic [4:0] t);
        expect_eq({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        expect_eq({tag, ".data"},  bus.out_data, d);
        expect_eq({tag, ".tag"},   64'(bus.out_tag), 64'(t));
    endtask

    task automatic run_one(input string tag, input shift_op_t op, input logic [63:0] d,
                           input logic [5:0] sh, input logic [63:0] exp);
        drive(op, d, sh, 5'd9);
        step();
        idle();
        expect_eq({tag, ".early"}, 64'(bus.out_valid), 64'd0);
        step();
        expect_out(tag, exp, 5'd9);
        expect_eq({tag, ".zero"}, 64'(bus.out_zero), 64'(exp == 64'd0));
        step();
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = SH_LSL;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        #12;
        expect_eq("rst.valid", 64'(bus.out_valid), 64'd0);
        expect_eq("rst.data",  bus.out_data, 64'd0);
        expect_eq("rst.tag",   64'(bus.out_tag), 64'd0);
        expect_eq("rst.zero",  64'(bus.out_zero), 64'd1);
        expect_eq("rst.ready", 64'(bus.in_ready), 64'd1);
        step();
        reset = 1'b0;
        step();

        // Back-to-back ops, then reset with two in flight
        drive(SH_LSR, 64'h8000000000000000, 6'd21, 5'd1);
        step();
        drive(SH_LSL, 64'h00000000000000FF, 6'd60, 5'd2);
        step();
        idle();
        expect_out("mid_a", 64'h0000040000000000, 5'd1);
        step();
        expect_out("mid_b", 64'hF000000000000000, 5'd2);
        step();
        drive(SH_LSL, 64'd1, 6'd1, 5'd3);
        step();
        drive(SH_LSL, 64'd1, 6'd2, 5'd4);
        step();
        idle();
        expect_eq("inflt.valid", 64'(bus.out_valid), 64'd1);
        reset = 1'b1;
        #1;
        expect_eq("rstnow.valid", 64'(bus.out_valid), 64'd0);
        expect_eq("rstnow.ready", 64'(bus.in_ready), 64'd1);
        step();
        step();
        reset = 1'b0;
        step();
        expect_eq("postrst.valid0", 64'(bus.out_valid), 64'd0);
        step();
        expect_eq("postrst.valid1", 64'(bus.out_valid), 64'd0);

        // Single ops: sign fill, rotate composition, zero and maximal amounts
        run_one("asr_neg63", SH_ASR, 64'h8000000000000000, 6'd63, 64'hFFFFFFFFFFFFFFFF);
        run_one("asr_pos63", SH_ASR, 64'h7FFFFFFFFFFFFFFF, 6'd63, 64'h0);
        run_one("asr_neg12", SH_ASR, 64'hF000000000000000, 6'd12, 64'hFFFF000000000000);
        run_one("ror_1",     SH_ROR, 64'h1, 6'd1, 64'h8000000000000000);
        run_one("ror_12",    SH_ROR, 64'h0123456789ABCDEF, 6'd12, 64'hDEF0123456789ABC);
        run_one("ror_63",    SH_ROR, 64'h1, 6'd63, 64'h2);
        run_one("lsl_63",    SH_LSL, 64'h3, 6'd63, 64'h8000000000000000);
        run_one("lsr_63",    SH_LSR, 64'hFFFFFFFFFFFFFFFF, 6'd63, 64'h1);
        run_one("lsl_0",     SH_LSL, 64'h0123456789ABCDEF, 6'd0, 64'h0123456789ABCDEF);
        run_one("lsr_0",     SH_LSR, 64'h0123456789ABCDEF, 6'd0, 64'h0123456789ABCDEF);
        run_one("asr_0",     SH_ASR, 64'h8123456789ABCDEF, 6'd0, 64'h8123456789ABCDEF);
        run_one("ror_0",     SH_ROR, 64'h0123456789ABCDEF, 6'd0, 64'h0123456789ABCDEF);

        // Backpressure: two ops stored, third held off, then drain in order
        bus.out_ready = 1'b0;
        drive(SH_LSL, 64'h1, 6'd4, 5'd11);
        expect_eq("bp.rdy0", 64'(bus.in_ready), 64'd1);
        step();
        drive(SH_LSR, 64'h100, 6'd8, 5'd12);
        expect_eq("bp.rdy1", 64'(bus.in_ready), 64'd1);
        step();
        drive(SH_ROR, 64'h1, 6'd1, 5'd13);
        expect_eq("bp.rdy2", 64'(bus.in_ready), 64'd0);
        step();
        expect_eq("bp.rdy3", 64'(bus.in_ready), 64'd0);
        expect_out("bp.hold0", 64'h10, 5'd11);
        step();
        expect_out("bp.hold1", 64'h10, 5'd11);
        bus.out_ready = 1'b1;
        #1;
        expect_eq("bp.rdy4", 64'(bus.in_ready), 64'd1);
        step();
        idle();
        expect_out("bp.out1", 64'h1, 5'd12);
        step();
        expect_out("bp.out2", 64'h8000000000000000, 5'd13);
        step();
        expect_eq("bp.drained", 64'(bus.out_valid), 64'd0);

        // Flush with two in flight and a new op offered in the flush cycle
        drive(SH_LSL, 64'hF, 6'd4, 5'd21);
        step();
        drive(SH_LSL, 64'hF, 6'd8, 5'd22);
        step();
        expect_out("fl.pre", 64'hF0, 5'd21);
        drive(SH_LSL, 64'hF, 6'd12, 5'd23);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        expect_eq("fl.v0", 64'(bus.out_valid), 64'd0);
        step();
        expect_eq("fl.v1", 64'(bus.out_valid), 64'd0);
        step();
        expect_eq("fl.v2", 64'(bus.out_valid), 64'd0);
        run_one("fl.after", SH_ROR, 64'h00000000000000AB, 6'd8, 64'hAB00000000000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
